// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer controller: state encoding and default sizing.
package mlp_pkg;

    localparam int MLP_INPUT_NODES = 24;
    localparam int MLP_ADDR_WIDTH  = 5;

    typedef enum logic [2:0] {
        LAYER_IDLE   = 3'd0,
        LAYER_CLEAR  = 3'd1,
        LAYER_STREAM = 3'd2,
        LAYER_DRAIN  = 3'd3,
        LAYER_VALID  = 3'd4
    } layer_state_t;

    // Plain-vector aliases of the enum for legacy-style state registers
    localparam logic [2:0] S_IDLE   = 3'(LAYER_IDLE);
    localparam logic [2:0] S_CLEAR  = 3'(LAYER_CLEAR);
    localparam logic [2:0] S_STREAM = 3'(LAYER_STREAM);
    localparam logic [2:0] S_DRAIN  = 3'(LAYER_DRAIN);
    localparam logic [2:0] S_VALID  = 3'(LAYER_VALID);

endpackage

// File: rtl/mlp_delay_line.sv
// Fixed-depth shift register with async reset and synchronous flush.
module mlp_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift one stage per cycle; flush empties every stage at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/mlp_layer_ctrl.sv
// Sequencer for one fully-connected layer: clear PEs, stream weight rows,
// wait for the memory/PE pipelines to drain, then hand results downstream.
module mlp_layer_ctrl
    import mlp_pkg::*;
#(
    parameter int INPUT_NODES = MLP_INPUT_NODES,
    parameter int ADDR_WIDTH  = MLP_ADDR_WIDTH,
    parameter int WMEM_LAT    = 1,
    parameter int PE_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_inputs,
    input  logic                  abort,
    output logic                  start_ready,
    output logic                  busy,
    output logic                  pe_clear,
    output logic                  weight_rd_en,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic                  mac_en,
    output logic [ADDR_WIDTH-1:0] input_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done
);

    localparam int DRAIN_CYCLES = WMEM_LAT + PE_LATENCY;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] MAX_N     = (ADDR_WIDTH + 1)'(INPUT_NODES);

    logic [2:0]            state, state_next;
    logic [ADDR_WIDTH:0]   n_reg, n_next;
    logic [ADDR_WIDTH:0]   cnt, cnt_next, cnt_inc;
    logic [DRAIN_W-1:0]    drain_cnt, drain_next;
    logic                  abort_hit;
    logic                  done_next;

    // Next-state decode; counters idle at zero so weight_addr is 0 outside STREAM
    always_comb begin
        state_next = state;
        n_next     = n_reg;
        cnt_next   = '0;
        drain_next = '0;
        done_next  = 1'b0;
        cnt_inc    = cnt + 1'b1;
        abort_hit  = abort && (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                    n_next     = (num_inputs > MAX_N) ? MAX_N : num_inputs;
                end
            end
            S_CLEAR: begin
                state_next = (n_reg != '0) ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                // Compare against N rather than wrap so the count can never overflow
                if (cnt_inc >= n_reg) state_next = S_DRAIN;
                else                  cnt_next   = cnt_inc;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_next = S_VALID;
                else                         drain_next = drain_cnt + 1'b1;
            end
            S_VALID: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Abort overrides everything, including a simultaneous handshake
        if (abort_hit) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            drain_next = '0;
            done_next  = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            n_reg     <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            n_reg     <= n_next;
            cnt       <= cnt_next;
            drain_cnt <= drain_next;
        end
    end

    // Registered status/strobe outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            pe_clear     <= 1'b0;
            weight_rd_en <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            start_ready  <= (state_next == S_IDLE);
            busy         <= (state_next != S_IDLE);
            pe_clear     <= (state_next == S_CLEAR);
            weight_rd_en <= (state_next == S_STREAM);
            out_valid    <= (state_next == S_VALID);
            done         <= done_next;
        end
    end

    assign weight_addr = cnt[ADDR_WIDTH-1:0];

    // Align mac_en/input_idx with weight data returning from memory
    mlp_delay_line #(
        .DEPTH (WMEM_LAT),
        .WIDTH (ADDR_WIDTH + 1)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .flush (abort_hit),
        .din   ({weight_rd_en, weight_addr}),
        .dout  ({mac_en, input_idx})
    );

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Directed bench for mlp_layer_ctrl at default parameters (WMEM_LAT=1, PE_LATENCY=2).
module tb_mlp_layer_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_inputs;
    logic          abort;
    logic          start_ready;
    logic          busy;
    logic          pe_clear;
    logic          weight_rd_en;
    logic [AW-1:0] weight_addr;
    logic          mac_en;
    logic [AW-1:0] input_idx;
    logic          out_valid;
    logic          out_ready;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mlp_layer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_inputs   (num_inputs),
        .abort        (abort),
        .start_ready  (start_ready),
        .busy         (busy),
        .pe_clear     (pe_clear),
        .weight_rd_en (weight_rd_en),
        .weight_addr  (weight_addr),
        .mac_en       (mac_en),
        .input_idx    (input_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " start_ready"}, 32'(start_ready), 1);
        check_eq({tag, " busy"}, 32'(busy), 0);
        check_eq({tag, " pe_clear"}, 32'(pe_clear), 0);
        check_eq({tag, " weight_rd_en"}, 32'(weight_rd_en), 0);
        check_eq({tag, " weight_addr"}, 32'(weight_addr), 0);
        check_eq({tag, " mac_en"}, 32'(mac_en), 0);
        check_eq({tag, " input_idx"}, 32'(input_idx), 0);
        check_eq({tag, " out_valid"}, 32'(out_valid), 0);
        check_eq({tag, " done"}, 32'(done), 0);
    endtask

    // Expected outputs k cycles after start acceptance for an effective length n
    task automatic check_cycle(input string tag, input int k, input int n);
        string t;
        bit    rd, mac;
        t   = $sformatf("%s k=%0d", tag, k);
        rd  = (k >= 2) && (k <= n + 1);
        mac = (k >= 3) && (k <= n + 2);
        check_eq({t, " pe_clear"}, 32'(pe_clear), 32'(k == 1));
        check_eq({t, " weight_rd_en"}, 32'(weight_rd_en), 32'(rd));
        check_eq({t, " weight_addr"}, 32'(weight_addr), rd ? 32'(k - 2) : 0);
        check_eq({t, " mac_en"}, 32'(mac_en), 32'(mac));
        check_eq({t, " input_idx"}, 32'(input_idx), mac ? 32'(k - 3) : 0);
        check_eq({t, " out_valid"}, 32'(out_valid), 32'(k == n + 5));
        check_eq({t, " done"}, 32'(done), 32'(k == n + 6));
        check_eq({t, " busy"}, 32'(busy), 32'((k >= 1) && (k <= n + 5)));
        check_eq({t, " start_ready"}, 32'(start_ready), 32'(!((k >= 1) && (k <= n + 5))));
    endtask

    // Issue start from the current cycle and check cycles 1..last after acceptance
    task automatic run_pass(input string tag, input int nin, input int n, input int last);
        num_inputs = 6'(nin);
        start      = 1'b1;
        step();
        start      = 1'b0;
        check_cycle(tag, 1, n);
        for (int k = 2; k <= last; k++) begin
            step();
            check_cycle(tag, k, n);
        end
    endtask

    initial begin
        bit seen;
        reset      = 1'b1;
        start      = 1'b0;
        num_inputs = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        #1;
        check_idle("reset asserted");
        repeat (3) step();
        reset = 1'b0;
        step();
        check_idle("after reset");

        // Full-length pass, downstream always ready
        run_pass("full24", 24, 24, 30);
        step();
        check_idle("full24 idle");

        // Zero-length pass
        run_pass("zero", 0, 0, 6);

        // Oversized request saturates to 24
        step();
        run_pass("sat31", 31, 24, 30);

        // Back-pressure: hold VALID, ignore start, then back-to-back pass
        step();
        out_ready = 1'b0;
        run_pass("bp3", 3, 3, 8);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            step();
            check_eq($sformatf("bp hold %0d out_valid", i), 32'(out_valid), 1);
            check_eq($sformatf("bp hold %0d pe_clear", i), 32'(pe_clear), 0);
            check_eq($sformatf("bp hold %0d start_ready", i), 32'(start_ready), 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("bp done", 32'(done), 1);
        check_eq("bp out_valid low", 32'(out_valid), 0);
        check_eq("bp start_ready", 32'(start_ready), 1);
        run_pass("b2b2", 2, 2, 8);

        // Abort mid-stream
        step();
        run_pass("abort", 24, 24, 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("after abort");
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid || done) seen = 1'b1;
        end
        check_eq("abort no valid/done", 32'(seen), 0);

        // Abort wins over a simultaneous handshake
        out_ready = 1'b0;
        run_pass("abortv", 0, 0, 5);
        abort     = 1'b1;
        out_ready = 1'b1;
        step();
        abort     = 1'b0;
        check_idle("abort+ready");
        step();
        check_eq("abort+ready later done", 32'(done), 0);

        // Async reset mid-stream, then a clean full pass
        run_pass("rst", 24, 24, 12);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async reset");
        #2;
        reset = 1'b0;
        step();
        check_idle("post reset");
        run_pass("full24b", 24, 24, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
